// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, state encoding and fixed addresses
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 4;
   localparam int unsigned APB_DATA_W = 16;

   localparam logic [APB_ADDR_W-1:0] RO_ID_ADDR = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_t;

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - fifteen writable 16-bit registers plus read-only ID word at the top address
module apb_regfile
   import apb_pkg::*;
#(
   parameter logic [APB_DATA_W-1:0] ID_VALUE = 16'hA5B0
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic                  we,
   input  logic [APB_ADDR_W-1:0] waddr,
   input  logic [APB_DATA_W-1:0] wdata,
   input  logic [APB_ADDR_W-1:0] raddr,
   output logic [APB_DATA_W-1:0] rdata
);

   logic [APB_DATA_W-1:0] mem [0:14];

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < 15; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != RO_ID_ADDR)) begin
         mem[waddr] <= wdata;
      end
   end

   // The ID address has no storage behind it; it always reads the constant.
   assign rdata = (raddr == RO_ID_ADDR) ? ID_VALUE : mem[raddr];

endmodule

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with programmable wait states, register file and error on ID write
module apb_slave
   import apb_pkg::*;
#(
   parameter int unsigned           WAIT_STATES = 0,
   parameter logic [APB_DATA_W-1:0] ID_VALUE    = 16'hA5B0
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic                  pselx,
   input  logic                  penable,
   input  logic [APB_ADDR_W-1:0] paddr,
   input  logic                  pwrite,
   input  logic [APB_DATA_W-1:0] pwdata,
   output logic                  pready,
   output logic [APB_DATA_W-1:0] prdata,
   output logic                  pslverr
);

   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   apb_state_t            state;
   logic [3:0]            cnt;
   logic [APB_ADDR_W-1:0] lat_addr;
   logic                  lat_write;
   logic [APB_DATA_W-1:0] lat_wdata;

   logic [APB_DATA_W-1:0] rd_data;
   logic [APB_DATA_W-1:0] cpl_rdata;
   logic                  cpl_err;
   logic                  wr_en;
   logic                  setup_req;

   assign setup_req = pselx && !penable;
   assign cpl_err   = lat_write && (lat_addr == RO_ID_ADDR);
   assign cpl_rdata = lat_write ? '0 : rd_data;

   // Commit happens on the edge that ends the completion cycle.
   assign wr_en = (state == ACCESS) && pready && lat_write && (lat_addr != RO_ID_ADDR);

   apb_regfile #(
      .ID_VALUE (ID_VALUE)
   ) u_regfile (
      .pclk     (pclk),
      .preset_n (preset_n),
      .we       (wr_en),
      .waddr    (lat_addr),
      .wdata    (lat_wdata),
      .raddr    (lat_addr),
      .rdata    (rd_data)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         pready    <= 1'b0;
         prdata    <= '0;
         pslverr   <= 1'b0;
      end else begin
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
         case (state)
            IDLE: begin
               // An ACCESS strobe with no preceding SETUP is a protocol violation and is dropped.
               if (setup_req) begin
                  state     <= SETUP;
                  lat_addr  <= paddr;
                  lat_write <= pwrite;
                  lat_wdata <= pwdata;
                  cnt       <= WS_INIT;
               end
            end
            SETUP: begin
               if (pselx && penable) begin
                  state <= ACCESS;
                  if (cnt == 4'd0) begin
                     pready  <= 1'b1;
                     prdata  <= cpl_rdata;
                     pslverr <= cpl_err;
                  end
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            ACCESS: begin
               if (pready) begin
                  state <= DONE;
               end else if (!pselx) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     pready  <= 1'b1;
                     prdata  <= cpl_rdata;
                     pslverr <= cpl_err;
                  end
               end
            end
            DONE: begin
               if (setup_req) begin
                  state     <= SETUP;
                  lat_addr  <= paddr;
                  lat_write <= pwrite;
                  lat_wdata <= pwdata;
                  cnt       <= WS_INIT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - directed bench for apb_slave at 0, 2 and 3 wait states
module tb_apb_slave;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic        psel;
   logic        penable;
   logic [3:0]  paddr;
   logic        pwrite;
   logic [15:0] pwdata;
   int          sel;

   logic        pready0, pready2, pready3;
   logic [15:0] prdata0, prdata2, prdata3;
   logic        pslverr0, pslverr2, pslverr3;
   logic        cur_pready;
   logic [15:0] cur_prdata;
   logic        cur_pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] rd;
   logic        er;
   int          wt;

   always #5 pclk = ~pclk;

   apb_slave #(.WAIT_STATES(0)) u_ws0 (
      .pclk(pclk), .preset_n(preset_n), .pselx(psel && sel == 0), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));

   apb_slave #(.WAIT_STATES(2)) u_ws2 (
      .pclk(pclk), .preset_n(preset_n), .pselx(psel && sel == 2), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready2), .prdata(prdata2), .pslverr(pslverr2));

   apb_slave #(.WAIT_STATES(3)) u_ws3 (
      .pclk(pclk), .preset_n(preset_n), .pselx(psel && sel == 3), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready3), .prdata(prdata3), .pslverr(pslverr3));

   always_comb begin
      cur_pready  = pready0;
      cur_prdata  = prdata0;
      cur_pslverr = pslverr0;
      if (sel == 2) begin
         cur_pready  = pready2;
         cur_prdata  = prdata2;
         cur_pslverr = pslverr2;
      end else if (sel == 3) begin
         cur_pready  = pready3;
         cur_prdata  = prdata3;
         cur_pslverr = pslverr3;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Ends at the negedge of the pready cycle, leaving the bus in ACCESS so a following
   // call issues its SETUP in the completer's DONE cycle. wt counts bus cycles with
   // penable high and pready low; -1 means pready never came.
   task automatic xfer(input int dut, input logic wr, input logic [3:0] a, input logic [15:0] d,
                       output logic [15:0] rdata, output logic err, output int waits);
      @(posedge pclk); #1;
      sel = dut; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = -1;
      rdata = 'x;
      err   = 1'bx;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (cur_pready) begin
            waits = i;
            rdata = cur_prdata;
            err   = cur_pslverr;
            break;
         end
      end
   endtask

   task automatic bus_idle();
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      preset_n = 1'b0;
      sel = 0; psel = 1'b1; penable = 1'b0; paddr = 4'd3; pwrite = 1'b0; pwdata = 16'h0;

      // Reset held with the bus selected and toggling penable.
      repeat (2) @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      check("rst_pready0", pready0, 1'b0);
      check("rst_prdata0", prdata0, 16'h0);
      check("rst_pslverr0", pslverr0, 1'b0);
      check("rst_pready3", pready3, 1'b0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      preset_n = 1'b1;

      xfer(0, 1'b0, 4'd3, 16'h0, rd, er, wt);
      check("ws0_rd3_data", rd, 16'h0000);
      check("ws0_rd3_wait", wt, 1);
      bus_idle();

      // Wait states 0: pready in the first ACCESS-state cycle, one cycle after the first penable cycle.
      xfer(0, 1'b1, 4'd2, 16'h1234, rd, er, wt);
      check("ws0_wr2_wait", wt, 1);
      check("ws0_wr2_err", er, 1'b0);
      check("ws0_wr2_prdata", rd, 16'h0);
      bus_idle();
      @(negedge pclk);
      check("ws0_wr2_one_cycle", pready0, 1'b0);
      xfer(0, 1'b0, 4'd2, 16'h0, rd, er, wt);
      check("ws0_rd2_data", rd, 16'h1234);
      check("ws0_rd2_err", er, 1'b0);
      bus_idle();

      // Wait states 3: ID register reads and rejected write.
      xfer(3, 1'b0, 4'hF, 16'h0, rd, er, wt);
      check("ws3_rd15_wait", wt, 4);
      check("ws3_rd15_data", rd, 16'hA5B0);
      bus_idle();
      @(negedge pclk);
      check("ws3_rd15_one_cycle", pready3, 1'b0);
      xfer(3, 1'b1, 4'hF, 16'hFFFF, rd, er, wt);
      check("ws3_wr15_err", er, 1'b1);
      check("ws3_wr15_wait", wt, 4);
      bus_idle();
      xfer(3, 1'b0, 4'hF, 16'h0, rd, er, wt);
      check("ws3_rd15_again", rd, 16'hA5B0);
      check("ws3_rd15_err", er, 1'b0);
      bus_idle();

      // Abort: pselx dropped after one ACCESS-state cycle.
      @(posedge pclk); #1;
      sel = 2; psel = 1'b1; penable = 1'b0; paddr = 4'd5; pwrite = 1'b1; pwdata = 16'hBEEF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("abort_setup_pready", pready2, 1'b0);
      @(negedge pclk);
      check("abort_access_pready", pready2, 1'b0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         check("abort_no_pready", pready2, 1'b0);
      end
      xfer(2, 1'b0, 4'd5, 16'h0, rd, er, wt);
      check("abort_rd5_data", rd, 16'h0000);
      check("abort_rd5_wait", wt, 3);
      bus_idle();

      // Back-to-back: the read SETUP lands in the write's DONE cycle.
      xfer(0, 1'b1, 4'd1, 16'h00AA, rd, er, wt);
      check("b2b_wr_wait", wt, 1);
      xfer(0, 1'b0, 4'd1, 16'h0, rd, er, wt);
      check("b2b_rd_data", rd, 16'h00AA);
      check("b2b_rd_wait", wt, 1);
      bus_idle();

      // penable without SETUP is ignored.
      @(posedge pclk); #1;
      sel = 0; psel = 1'b1; penable = 1'b1; paddr = 4'd2; pwrite = 1'b1; pwdata = 16'h9999;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         check("noset_pready", pready0, 1'b0);
      end
      bus_idle();
      xfer(0, 1'b0, 4'd2, 16'h0, rd, er, wt);
      check("noset_rd2_data", rd, 16'h1234);
      bus_idle();

      // Reset in the middle of a write drops it and clears state.
      @(posedge pclk); #1;
      sel = 3; psel = 1'b1; penable = 1'b0; paddr = 4'd4; pwrite = 1'b1; pwdata = 16'h4444;
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (2) @(negedge pclk);
      preset_n = 1'b0;
      #1;
      check("midrst_pready", pready3, 1'b0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      preset_n = 1'b1;
      xfer(3, 1'b0, 4'd4, 16'h0, rd, er, wt);
      check("midrst_rd4_data", rd, 16'h0000);
      bus_idle();
      xfer(0, 1'b0, 4'd2, 16'h0, rd, er, wt);
      check("midrst_rd2_cleared", rd, 16'h0000);
      bus_idle();

      repeat (2) @(posedge pclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
